// File: rtl/rand_arbiter_pkg.sv
// Shared definitions for the random-number arbiter: FSM encoding, LFSR width,
// reset seed and feedback taps.
package rand_arbiter_pkg;

    localparam int unsigned LFSR_W = 10;

    // Value the LFSR holds after reset.
    localparam logic [LFSR_W-1:0] LFSR_SEED_DEFAULT = 10'h155;

    // Right-shifting Galois form: old[0] is fed back into bits 9, 8, 6 and 5.
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 10'h360;

    // A zero seed would lock the LFSR, so it is replaced by this value.
    localparam logic [LFSR_W-1:0] LFSR_ZERO_SUBST = 10'h001;

    typedef enum logic [1:0] {
        StIdle,
        StReduce,
        StDone
    } arb_state_e;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
        return (cur >> 1) ^ (cur[0] ? LFSR_TAPS : '0);
    endfunction

endpackage

// File: rtl/rand_arbiter_if.sv
// Request/result bus between requesters (master) and the arbiter (slave).
interface rand_arbiter_if #(
    parameter int unsigned N_REQ = 3
);
    logic                  reseed;
    logic [9:0]            seed;
    logic [N_REQ-1:0]      req;
    logic [10*N_REQ-1:0]   lim_flat;
    logic [N_REQ-1:0]      ack;
    logic [9:0]            rand_val;
    logic [1:0]            grant_id;
    logic                  busy;

    modport master (
        output reseed, seed, req, lim_flat,
        input  ack, rand_val, grant_id, busy
    );

    modport slave (
        input  reseed, seed, req, lim_flat,
        output ack, rand_val, grant_id, busy
    );
endinterface

// File: rtl/lfsr10_core.sv
// Free-running 10-bit LFSR with synchronous reset and parallel load.
module lfsr10_core
    import rand_arbiter_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = LFSR_SEED_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [LFSR_W-1:0] load_val,
    output logic [LFSR_W-1:0] state
);

    logic [LFSR_W-1:0] r_state;

    // Reset beats load, load beats advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SEED;
        end else if (load) begin
            r_state <= load_val;
        end else begin
            r_state <= lfsr_next(r_state);
        end
    end

    assign state = r_state;

endmodule

// File: rtl/rand_arbiter.sv
// Round-robin arbiter that hands each winner a random value reduced modulo its
// own limit, using a 10-step restoring modulo datapath.
module rand_arbiter
    import rand_arbiter_pkg::*;
#(
    parameter int unsigned       N_REQ        = 3,
    parameter logic [LFSR_W-1:0] SEED_DEFAULT = LFSR_SEED_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    rand_arbiter_if.slave arb_bus
);

    arb_state_e  r_state, w_state_next;
    logic [1:0]  r_last, w_last_next;
    logic [1:0]  r_grant, w_grant_next;
    logic [9:0]  r_opnd, w_opnd_next;
    logic [9:0]  r_lim, w_lim_next;
    logic [9:0]  r_rand, w_rand_next;
    logic [3:0]  r_k, w_k_next;

    logic [9:0]  w_lfsr;
    logic [9:0]  w_load_val;
    logic        w_any_req;
    logic        w_found_hi;
    logic [1:0]  w_lo_idx;
    logic [1:0]  w_hi_idx;
    logic [1:0]  w_winner;
    logic [9:0]  w_win_lim;
    logic [18:0] w_shifted;
    logic [9:0]  w_step;
    logic [N_REQ-1:0] w_ack;

    assign w_load_val = (arb_bus.seed == '0) ? LFSR_ZERO_SUBST : arb_bus.seed;

    lfsr10_core #(
        .SEED (SEED_DEFAULT)
    ) u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .load     (arb_bus.reseed),
        .load_val (w_load_val),
        .state    (w_lfsr)
    );

    // Round-robin pick: first requester above last_grant, else lowest requester.
    always_comb begin
        w_any_req  = 1'b0;
        w_found_hi = 1'b0;
        w_lo_idx   = '0;
        w_hi_idx   = '0;
        w_win_lim  = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (!w_any_req && arb_bus.req[i]) begin
                w_any_req = 1'b1;
                w_lo_idx  = 2'(i);
            end
            if (!w_found_hi && arb_bus.req[i] && (i > int'(r_last))) begin
                w_found_hi = 1'b1;
                w_hi_idx   = 2'(i);
            end
        end
        w_winner = w_found_hi ? w_hi_idx : w_lo_idx;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (w_winner == 2'(i)) begin
                w_win_lim = arb_bus.lim_flat[i*10 +: 10];
            end
        end
    end

    // One restoring-modulo step; the 19-bit compare keeps lim<<9 exact.
    always_comb begin
        w_shifted = {9'd0, r_lim} << r_k;
        w_step    = r_opnd;
        if ({9'd0, r_opnd} >= w_shifted) begin
            // Subtrahend is <= operand here, so its upper bits are zero.
            w_step = r_opnd - w_shifted[9:0];
        end
    end

    // FSM next-state and datapath updates.
    always_comb begin
        w_state_next = r_state;
        w_last_next  = r_last;
        w_grant_next = r_grant;
        w_opnd_next  = r_opnd;
        w_lim_next   = r_lim;
        w_rand_next  = r_rand;
        w_k_next     = r_k;
        unique case (r_state)
            StIdle: begin
                if (w_any_req) begin
                    w_state_next = StReduce;
                    w_opnd_next  = w_lfsr;
                    w_lim_next   = w_win_lim;
                    w_grant_next = w_winner;
                    w_k_next     = 4'd9;
                end
            end
            StReduce: begin
                w_opnd_next = w_step;
                w_k_next    = r_k - 4'd1;
                if (r_k == 4'd0) begin
                    w_state_next = StDone;
                    w_rand_next  = w_step;
                end
            end
            StDone: begin
                w_state_next = StIdle;
                w_last_next  = r_grant;
            end
            default: w_state_next = StIdle;
        endcase
    end

    // State register; reset abandons any in-flight operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_last  <= 2'(N_REQ - 1);
            r_grant <= '0;
            r_opnd  <= '0;
            r_lim   <= '0;
            r_rand  <= '0;
            r_k     <= '0;
        end else begin
            r_state <= w_state_next;
            r_last  <= w_last_next;
            r_grant <= w_grant_next;
            r_opnd  <= w_opnd_next;
            r_lim   <= w_lim_next;
            r_rand  <= w_rand_next;
            r_k     <= w_k_next;
        end
    end

    // Ack pulse goes only to the granted requester while in DONE.
    always_comb begin
        w_ack = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            w_ack[i] = (r_state == StDone) && (r_grant == 2'(i));
        end
    end

    assign arb_bus.ack      = w_ack;
    assign arb_bus.rand_val = r_rand;
    assign arb_bus.grant_id = r_grant;
    assign arb_bus.busy     = (r_state != StIdle);

endmodule

// File: tb/tb_rand_arbiter.sv
// Self-checking bench for rand_arbiter: directed scenarios plus randomized
// traffic, all compared against a cycle-level behavioural model.
module tb_rand_arbiter;

    localparam int NR = 3;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    logic chk_en;

    rand_arbiter_if #(.N_REQ(NR)) bus ();

    rand_arbiter #(
        .N_REQ (NR)
    ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .arb_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // LFSR rule written straight from the bit equations.
    function automatic logic [9:0] lfsr_step(input logic [9:0] o);
        logic [9:0] n;
        n[9]   = o[0];
        n[8]   = o[9] ^ o[0];
        n[7]   = o[8];
        n[6]   = o[7] ^ o[0];
        n[5]   = o[6] ^ o[0];
        n[4:0] = o[5:1];
        return n;
    endfunction

    // Model: m_phase counts cycles since grant (0 = idle, 11 = result cycle).
    int         m_phase;
    int         m_last;
    int         m_gid;
    int         m_exp;
    logic [9:0] m_lfsr;
    logic [9:0] m_rand;

    always @(posedge clk) begin : model
        int         idx;
        logic       fnd;
        logic [9:0] pre;
        int         lim;
        if (rst) begin
            m_lfsr  = 10'h155;
            m_phase = 0;
            m_last  = NR - 1;
            m_gid   = 0;
            m_rand  = '0;
        end else begin
            pre    = m_lfsr;
            m_lfsr = bus.reseed ? ((bus.seed == 0) ? 10'h001 : bus.seed) : lfsr_step(m_lfsr);
            if (m_phase == 0) begin
                fnd = 1'b0;
                for (int off = 1; off <= NR; off++) begin
                    idx = (m_last + off) % NR;
                    if (!fnd && bus.req[idx]) begin
                        fnd   = 1'b1;
                        m_gid = idx;
                    end
                end
                if (fnd) begin
                    lim     = int'(bus.lim_flat[m_gid*10 +: 10]);
                    m_exp   = (lim == 0) ? int'(pre) : int'(pre) % lim;
                    m_phase = 1;
                end
            end else if (m_phase == 11) begin
                m_phase = 0;
                m_last  = m_gid;
            end else begin
                m_phase++;
                if (m_phase == 11) m_rand = 10'(m_exp);
            end
        end
    end

    // Compare every output against the model on the falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check_eq("busy", 32'(bus.busy), 32'(m_phase != 0));
            check_eq("ack", 32'(bus.ack), (m_phase == 11) ? (32'd1 << m_gid) : 32'd0);
            check_eq("rand_val", 32'(bus.rand_val), 32'(m_rand));
            check_eq("grant_id", 32'(bus.grant_id), 32'(m_gid));
            check_eq("lfsr", 32'(u_dut.u_lfsr.state), 32'(m_lfsr));
        end
    end

    task automatic wait_ack(input int idx, input int maxc, output int cyc);
        cyc = 0;
        for (int c = 1; c <= maxc; c++) begin
            @(negedge clk);
            if (cyc == 0 && bus.ack[idx]) cyc = c;
            if (cyc != 0) break;
        end
    endtask

    task automatic wait_any_ack(input int maxc, output int cyc, output int idx);
        cyc = 0;
        idx = -1;
        for (int c = 1; c <= maxc; c++) begin
            @(negedge clk);
            if (bus.ack != '0) begin
                cyc = c;
                for (int i = 0; i < NR; i++) if (bus.ack[i]) idx = i;
                break;
            end
        end
    endtask

    task automatic set_lim(input int i, input logic [9:0] v);
        bus.lim_flat[i*10 +: 10] = v;
    endtask

    function automatic logic [9:0] pick_lim();
        case ($urandom_range(0, 5))
            0:       return 10'd0;
            1:       return 10'd1;
            2:       return 10'h3FF;
            3:       return 10'($urandom_range(2, 15));
            default: return 10'($urandom_range(0, 1023));
        endcase
    endfunction

    initial begin
        int         c;
        int         idx;
        logic [9:0] s;
        logic [9:0] l;
        logic [NR-1:0] seen;
        int         exp_order [4];
        n_checks = 0;
        n_fail   = 0;
        chk_en   = 1'b0;
        rst      = 1'b1;
        bus.reseed   = 1'b0;
        bus.seed     = '0;
        bus.req      = '0;
        bus.lim_flat = '0;
        @(negedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        rst    = 1'b0;

        // Reseed 3FF, lim0=10 -> 1023 mod 10 = 3.
        bus.reseed = 1'b1;
        bus.seed   = 10'h3FF;
        @(negedge clk);
        bus.reseed = 1'b0;
        set_lim(0, 10'd10);
        bus.req = 3'b001;
        wait_ack(0, 20, c);
        check_eq("s1_latency", 32'(c), 32'd11);
        check_eq("s1_rand", 32'(bus.rand_val), 32'd3);
        check_eq("s1_gid", 32'(bus.grant_id), 32'd0);
        bus.req = '0;
        @(negedge clk);

        // Zero seed becomes 001; lim 0 passes the snapshot through.
        bus.reseed = 1'b1;
        bus.seed   = 10'h000;
        @(negedge clk);
        bus.reseed = 1'b0;
        set_lim(1, 10'd0);
        bus.req = 3'b010;
        @(negedge clk);
        check_eq("s2_lfsr_after_grant", 32'(u_dut.u_lfsr.state), 32'h360);
        wait_ack(1, 20, c);
        check_eq("s2_latency", 32'(c), 32'd10);
        check_eq("s2_rand", 32'(bus.rand_val), 32'h001);
        check_eq("s2_gid", 32'(bus.grant_id), 32'd1);
        bus.req = '0;
        @(negedge clk);

        // From reset, all requesting: order 0,1,2,0 with 12-cycle spacing.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NR; i++) set_lim(i, 10'd0);
        bus.req = 3'b111;
        exp_order = '{0, 1, 2, 0};
        for (int k = 0; k < 4; k++) begin
            wait_any_ack(20, c, idx);
            check_eq("s3_order", 32'(idx), 32'(exp_order[k]));
            check_eq("s3_gap", 32'(c), (k == 0) ? 32'd11 : 32'd12);
        end
        bus.req = '0;
        @(negedge clk);
        @(negedge clk);

        // lim=1 yields 0; lim=3FF with snapshot 3FF yields 0.
        bus.reseed = 1'b1;
        bus.seed   = 10'($urandom_range(1, 1023));
        @(negedge clk);
        bus.reseed = 1'b0;
        set_lim(2, 10'd1);
        bus.req = 3'b100;
        wait_ack(2, 20, c);
        check_eq("s4_lim1", 32'(bus.rand_val), 32'd0);
        bus.req = '0;
        @(negedge clk);
        bus.reseed = 1'b1;
        bus.seed   = 10'h3FF;
        @(negedge clk);
        bus.reseed = 1'b0;
        set_lim(2, 10'h3FF);
        bus.req = 3'b100;
        wait_ack(2, 20, c);
        check_eq("s4_lim3ff", 32'(bus.rand_val), 32'd0);
        bus.req = '0;
        @(negedge clk);

        // Reset on the 5th REDUCE cycle abandons the operation.
        set_lim(0, 10'd7);
        bus.req = 3'b001;
        repeat (5) @(negedge clk);
        rst     = 1'b1;
        bus.req = '0;
        @(negedge clk);
        check_eq("s5_busy", 32'(bus.busy), 32'd0);
        check_eq("s5_ack", 32'(bus.ack), 32'd0);
        check_eq("s5_rand", 32'(bus.rand_val), 32'd0);
        rst  = 1'b0;
        seen = '0;
        repeat (15) begin
            @(negedge clk);
            seen = seen | bus.ack;
        end
        check_eq("s5_no_ack", 32'(seen), 32'd0);

        // Reseed and limit change mid-flight do not disturb the result.
        s = 10'($urandom_range(1, 1023));
        l = 10'($urandom_range(2, 1023));
        for (int run = 0; run < 2; run++) begin
            bus.reseed = 1'b1;
            bus.seed   = s;
            @(negedge clk);
            bus.reseed = 1'b0;
            set_lim(0, l);
            bus.req = 3'b001;
            if (run == 1) begin
                repeat (3) @(negedge clk);
                bus.reseed = 1'b1;
                bus.seed   = 10'($urandom_range(0, 1023));
                set_lim(0, 10'($urandom_range(0, 1023)));
                @(negedge clk);
                bus.reseed = 1'b0;
                wait_ack(0, 20, c);
                check_eq("s6_latency_reseed", 32'(c), 32'd7);
            end else begin
                wait_ack(0, 20, c);
                check_eq("s6_latency", 32'(c), 32'd11);
            end
            check_eq("s6_rand", 32'(bus.rand_val), 32'(int'(s) % int'(l)));
            bus.req = '0;
            @(negedge clk);
        end

        // Randomized traffic against the model.
        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(negedge clk);
            rst        = ($urandom_range(0, 399) == 0);
            bus.reseed = ($urandom_range(0, 29) == 0);
            bus.seed   = ($urandom_range(0, 3) == 0) ? 10'd0 : 10'($urandom_range(0, 1023));
            for (int i = 0; i < NR; i++) begin
                if (bus.req[i] && bus.ack[i]) begin
                    bus.req[i] = 1'b0;
                end else if (!bus.req[i] && $urandom_range(0, 3) == 0) begin
                    bus.req[i] = 1'b1;
                    set_lim(i, pick_lim());
                end else if (bus.req[i] && $urandom_range(0, 199) == 0) begin
                    bus.req[i] = 1'b0;
                end
                if ($urandom_range(0, 19) == 0) set_lim(i, pick_lim());
            end
        end
        @(negedge clk);
        rst = 1'b0;
        bus.req = '0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rand_arbiter.md
RAND_ARBITER -- requirements
Module: rand_arbiter

Interface
REQ-001 Parameter N_REQ, default 3, number of requesters (2..4).
REQ-002 Parameter SEED_DEFAULT, default 10'h155, LFSR value loaded at reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 reseed  input  1  one-cycle pulse; load seed into LFSR.
REQ-006 seed  input  10  reseed value.
REQ-007 req  input  N_REQ  per-requester level request, held until matching ack.
REQ-008 lim_flat  input  10*N_REQ  per-requester exclusive upper bound; requester i at bits [10i+9:10i].
REQ-009 ack  output  N_REQ  one-cycle completion pulse to the granted requester.
REQ-010 rand_val  output  10  reduced random result; valid while ack is high.
REQ-011 grant_id  output  2  index of the requester currently or last served.
REQ-012 busy  output  1  high in REDUCE and DONE.

Function
REQ-013 LFSR shall advance every cycle when not reloading: new[9]=old[0]; new[8]=old[9]^old[0]; new[7]=old[8]; new[6]=old[7]^old[0]; new[5]=old[6]^old[0]; new[4:0]=old[5:1].
REQ-014 A reseed pulse shall load seed, or 10'h001 if seed==0; reseed outranks advance.
REQ-015 FSM states: IDLE, REDUCE, DONE.
REQ-016 IDLE with any req high: the grant edge shall select a requester round-robin, starting at (last_grant+1) mod N_REQ.
REQ-017 The grant edge shall capture the pre-edge LFSR value as the operand.
REQ-018 The grant edge shall capture the winner's limit.
REQ-019 The grant edge shall set grant_id and go to REDUCE.
REQ-020 REDUCE shall run exactly 10 cycles of restoring modulo, k=9 down to 0: if operand >= (lim<<k), subtract. Compare width is 19 bits; no truncation.
REQ-021 lim==0 shall mean no reduction (result = snapshot); lim==1 shall yield 0.
REQ-022 After the k=0 step the FSM shall enter DONE. ack[grant_id] shall be high for exactly that one cycle, i.e. 10 cycles after the grant edge, and rand_val = snapshot mod lim.
REQ-023 DONE shall return to IDLE and update last_grant. The earliest next grant edge is the edge after that, giving a throughput of one result per 12 cycles.
REQ-024 rand_val shall hold its value until the next DONE.
REQ-025 A req drop mid-operation shall not abort; ack is still pulsed and the requester ignores it.
REQ-026 Reseed during REDUCE/DONE shall not alter the in-flight operand.
REQ-027 lim_flat changes after the grant edge shall not affect the result.

Reset
REQ-028 rst high shall force state to IDLE, abandoning any in-flight operation.
REQ-029 rst high shall set ack=0, rand_val=0, grant_id=0, busy=0.
REQ-030 rst high shall set last_grant=N_REQ-1, so requester 0 wins first, and LFSR=SEED_DEFAULT.
REQ-031 rst shall outrank reseed and req in the same cycle.

Structure
REQ-032 A shared package shall hold the FSM state encoding, SEED_DEFAULT, LFSR width (10) and the tap definition.
REQ-033 The LFSR shall be one sub-module, lfsr10_core (clk, rst, load, load_val, state), instanced once.
REQ-034 Arbitration, modulo datapath and FSM shall live in rand_arbiter.

Verification
REQ-035 Scenario: reseed seed=10'h3FF, then next cycle req[0]=1 with lim0=10 -> ack[0] 10 cycles after grant, rand_val=3, grant_id=0.
REQ-036 Scenario: reseed seed=0, then req[1]=1 with lim1=0 -> rand_val=10'h001; LFSR value one cycle after the grant edge = 10'h360.
REQ-037 Scenario: from reset, req=3'b111 held, all limits 0 -> ack order 0,1,2,0, with successive acks 12 cycles apart.
REQ-038 Scenario: lim=1 with any seed -> rand_val=0; lim=10'h3FF with snapshot 10'h3FF -> rand_val=0.
REQ-039 Scenario: rst asserted on the 5th REDUCE cycle -> next cycle busy=0, ack=0, rand_val=0, and no ack until a new request.
REQ-040 Scenario: reseed pulsed on the 3rd REDUCE cycle -> in-flight rand_val unchanged versus the run without reseed.
